// File: rtl/keyboard_pkg.sv
// Shared types, scan codes and key-to-action map for the PS/2 keyboard decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package keyboard_pkg;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'b000,
    ACT_UP     = 3'b001,
    ACT_DOWN   = 3'b010,
    ACT_LEFT   = 3'b011,
    ACT_RIGHT  = 3'b100,
    ACT_SELECT = 3'b101,
    ACT_HALF   = 3'b110,
    ACT_CANCEL = 3'b111
  } action_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_Q     = 8'h15;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Translate a make code (with its E0 flag) into a game action; unmapped keys give ACT_NONE.
  function automatic action_t map_action(input logic ext, input logic [7:0] code);
    action_t act;
    act = ACT_NONE;
    if (ext) begin
      case (code)
        SC_UP:    act = ACT_UP;
        SC_DOWN:  act = ACT_DOWN;
        SC_LEFT:  act = ACT_LEFT;
        SC_RIGHT: act = ACT_RIGHT;
        default:  act = ACT_NONE;
      endcase
    end else begin
      case (code)
        SC_W:     act = ACT_UP;
        SC_S:     act = ACT_DOWN;
        SC_A:     act = ACT_LEFT;
        SC_D:     act = ACT_RIGHT;
        SC_SPACE: act = ACT_SELECT;
        SC_Q:     act = ACT_HALF;
        SC_ESC:   act = ACT_CANCEL;
        default:  act = ACT_NONE;
      endcase
    end
    return act;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise lines, shift 11-bit frames, check start/parity/stop, timeout.
// Latency: byte_valid/frame_error one clock after the synchronised 11th falling edge.
// Backpressure: none; byte_valid is a single-cycle strobe that must be consumed immediately.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic [10:0]            r_shift;
  logic [3:0]             r_bit_cnt;
  logic [TW-1:0]          r_timeout;
  logic                   r_byte_valid;
  logic [7:0]             r_byte_data;
  logic                   r_frame_error;

  logic        w_clk_s;
  logic        w_dat_s;
  logic        w_fall;
  logic [10:0] w_frame;
  logic        w_frame_ok;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  // Frame as it will look once the current bit is shifted in (bit 0 = start bit).
  assign w_frame    = {w_dat_s, r_shift[10:1]};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  // Synchronisers and falling-edge history; lines reset to their idle-high level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  // Bit assembly, frame check and partial-frame timeout; an edge always beats a timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_timeout     <= '0;
      r_byte_valid  <= 1'b0;
      r_byte_data   <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_fall) begin
        r_shift   <= w_frame;
        r_timeout <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt     <= '0;
          r_byte_data   <= w_frame[8:1];
          r_byte_valid  <= w_frame_ok;
          r_frame_error <= ~w_frame_ok;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt     <= '0;
          r_timeout     <= '0;
          r_frame_error <= 1'b1;
        end else begin
          r_timeout <= r_timeout + TW'(1);
        end
      end else begin
        r_timeout <= '0;
      end
    end
  end

  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign frame_error = r_frame_error;

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard to game-action decoder: scan-code FSM (E0/F0 prefixes), key map, repeat suppression.
// Latency: keyboard_locker one clock after the byte_valid that completes a make.
// Backpressure: none; keyboard_locker is a single-cycle strobe, keyboard_data holds until the next one.
module keyboard_decoder
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       keyboard_locker,
  output logic [2:0] keyboard_data,
  output logic       frame_error
);

  logic       w_byte_vld;
  logic [7:0] w_byte_dat;
  logic       w_frame_err;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .byte_valid (w_byte_vld),
    .byte_data  (w_byte_dat),
    .frame_error(w_frame_err)
  );

  dec_state_t r_state;
  logic [8:0] r_held;
  logic       r_locker;
  logic [2:0] r_data;

  logic       w_is_prefix;
  logic       w_is_make;
  logic       w_is_brk;
  logic       w_ext;
  logic [8:0] w_key;
  action_t    w_act;

  // Classify the incoming byte as make/break and attach the extended flag from the current state.
  always_comb begin
    w_is_prefix = (w_byte_dat == SC_EXT) || (w_byte_dat == SC_BRK);
    w_is_make   = 1'b0;
    w_is_brk    = 1'b0;
    w_ext       = 1'b0;
    case (r_state)
      ST_IDLE:    w_is_make = ~w_is_prefix;
      ST_EXT: begin
        w_is_make = ~w_is_prefix;
        w_ext     = 1'b1;
      end
      ST_BRK:     w_is_brk  = 1'b1;
      ST_EXT_BRK: begin
        w_is_brk  = 1'b1;
        w_ext     = 1'b1;
      end
      default:    w_is_make = 1'b0;
    endcase
    w_key = {w_ext, w_byte_dat};
    w_act = map_action(w_ext, w_byte_dat);
  end

  // Scan-code FSM with registered strobe, action and held-key tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_held   <= '0;
      r_locker <= 1'b0;
      r_data   <= 3'b000;
    end else begin
      r_locker <= 1'b0;
      if (w_byte_vld) begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_dat == SC_EXT)      r_state <= ST_EXT;
            else if (w_byte_dat == SC_BRK) r_state <= ST_BRK;
            else                           r_state <= ST_IDLE;
          end
          ST_EXT: begin
            if (w_byte_dat == SC_BRK)      r_state <= ST_EXT_BRK;
            else if (w_byte_dat == SC_EXT) r_state <= ST_EXT;
            else                           r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_is_make && (w_act != ACT_NONE) && (w_key != r_held)) begin
          r_locker <= 1'b1;
          r_data   <= w_act;
          r_held   <= w_key;
        end else if (w_is_brk && (w_key == r_held)) begin
          r_held <= '0;
        end
      end
    end
  end

  assign keyboard_locker = r_locker;
  assign keyboard_data   = r_data;
  assign frame_error     = w_frame_err;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed bench for keyboard_decoder: drives PS/2 frames and checks strobe counts and action codes.
module tb_keyboard_decoder;

  localparam int TO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       keyboard_locker;
  logic [2:0] keyboard_data;
  logic       frame_error;

  int n_checks = 0;
  int n_err    = 0;
  int n_lock   = 0;
  int n_ferr   = 0;
  int exp_lock = 0;
  int exp_ferr = 0;

  keyboard_decoder #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .keyboard_locker(keyboard_locker),
    .keyboard_data  (keyboard_data),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  // Count high cycles of each strobe; a stretched strobe shows up as an extra count.
  always @(negedge clock) begin
    if (keyboard_locker) n_lock++;
    if (frame_error)     n_ferr++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(4);
    ps2_clock = 1'b0;
    wait_clks(8);
    ps2_clock = 1'b1;
    wait_clks(4);
  endtask

  // Send the first nbits of a frame for byte d; bad_par flips the odd-parity bit.
  task automatic send_frame_bits(input logic [7:0] d, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    wait_clks(6);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame_bits(d, 1'b0, 11);
  endtask

  initial begin
    wait_clks(5);
    check_val("rst_locker", {31'd0, keyboard_locker}, 32'd0);
    check_val("rst_data", {29'd0, keyboard_data}, 32'd0);
    check_val("rst_ferr", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    wait_clks(5);

    // W press then release: one strobe, break silent, release clears held so W strobes again
    send_byte(8'h1D); exp_lock++;
    check_val("w_cnt", n_lock, exp_lock);
    check_val("w_data", {29'd0, keyboard_data}, 32'd1);
    send_byte(8'hF0); send_byte(8'h1D);
    check_val("w_brk_cnt", n_lock, exp_lock);
    send_byte(8'h1D); exp_lock++;
    check_val("w_again_cnt", n_lock, exp_lock);

    // Right arrow typematic x3, then break, then press again
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hE0); send_byte(8'h74);
    end
    exp_lock++;
    check_val("right_rep_cnt", n_lock, exp_lock);
    check_val("right_data", {29'd0, keyboard_data}, 32'd4);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check_val("right_brk_cnt", n_lock, exp_lock);
    send_byte(8'hE0); send_byte(8'h74); exp_lock++;
    check_val("right_again_cnt", n_lock, exp_lock);

    // Parity error on Space, then a good Space
    send_frame_bits(8'h29, 1'b1, 11); exp_ferr++;
    check_val("par_ferr", n_ferr, exp_ferr);
    check_val("par_lock", n_lock, exp_lock);
    check_val("par_data_hold", {29'd0, keyboard_data}, 32'd4);
    send_byte(8'h29); exp_lock++;
    check_val("space_cnt", n_lock, exp_lock);
    check_val("space_data", {29'd0, keyboard_data}, 32'd5);

    // Partial frame times out, then Esc
    send_frame_bits(8'h76, 1'b0, 5);
    check_val("to_early_ferr", n_ferr, exp_ferr);
    wait_clks(TO + 20); exp_ferr++;
    check_val("to_ferr", n_ferr, exp_ferr);
    check_val("to_lock", n_lock, exp_lock);
    send_byte(8'h76); exp_lock++;
    check_val("esc_cnt", n_lock, exp_lock);
    check_val("esc_data", {29'd0, keyboard_data}, 32'd7);
    check_val("esc_ferr", n_ferr, exp_ferr);

    // A held, D pressed, A released: held stays D so D repeat is silent
    send_byte(8'h1C); exp_lock++;
    check_val("a_cnt", n_lock, exp_lock);
    check_val("a_data", {29'd0, keyboard_data}, 32'd3);
    send_byte(8'h23); exp_lock++;
    check_val("d_cnt", n_lock, exp_lock);
    check_val("d_data", {29'd0, keyboard_data}, 32'd4);
    send_byte(8'hF0); send_byte(8'h1C);
    check_val("a_rel_cnt", n_lock, exp_lock);
    send_byte(8'h23);
    check_val("d_held_cnt", n_lock, exp_lock);

    // Reset after E0 plus a partial frame; next 1B must decode as plain S
    send_byte(8'hE0);
    send_frame_bits(8'h72, 1'b0, 6);
    reset = 1'b1;
    wait_clks(2);
    check_val("mid_rst_locker", {31'd0, keyboard_locker}, 32'd0);
    check_val("mid_rst_data", {29'd0, keyboard_data}, 32'd0);
    check_val("mid_rst_ferr", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    wait_clks(TO + 20);
    check_val("post_rst_ferr", n_ferr, exp_ferr);
    send_byte(8'h1B); exp_lock++;
    check_val("s_cnt", n_lock, exp_lock);
    check_val("s_data", {29'd0, keyboard_data}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
